dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the multicycle ARM core's data port.
// It accepts one load/store at a time and answers after a fixed latency with a ready pulse and an error flag.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   cur_addr;
    logic          cur_we;
    logic          cur_bad;
    logic [IW-1:0] cur_idx;
    logic [IW-1:0] wr_idx;
    logic          enter_resp;
    logic          wr_en;

    // With LATENCY=1 the response is formed in the acceptance cycle, before
    // the request is visible in the capture registers, so look at the port.
    assign cur_addr = (state == IDLE) ? addr : addr_q;
    assign cur_we   = (state == IDLE) ? we   : we_q;
    assign cur_bad  = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[31:2]} >= DEPTH_W);
    assign cur_idx  = cur_addr[IW+1:2];
    assign wr_idx   = addr_q[IW+1:2];

    assign enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 4'd1));

    // err is high in RESP exactly when the captured address was rejected.
    assign wr_en = (state == RESP) && we_q && !err && !reset;

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; blocking would create order-dependent races.
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            cnt   <= 4'd0;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                ready <= 1'b1;
                err   <= cur_bad;
                if (cur_bad) begin
                    rdata <= 32'd0;
                end else if (!cur_we) begin
                    rdata <= mem[cur_idx];
                end
            end else begin
                ready <= 1'b0;
                err   <= 1'b0;
            end
        end
    end

    // NOTE: the RAM array has no reset; its contents are undefined at power-up
    // and clearing it would defeat block-RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 2, 1 and 15 share one clock and reset.
// Expected responses come from a bench-side memory model and are popped when ready is seen.
module tb_dmem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 64;

    typedef struct {
        int          inst;
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [31:0] addr_v  [NI];
    logic [31:0] wdata_v [NI];
    logic [2:0]  ready_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;
    logic [31:0] rdata_v [NI];

    int          total;
    int          bad;
    int          cyc;
    logic        mon_on;
    exp_t        sb [$];
    logic [31:0] mdl [NI][DEPTH];
    logic [31:0] last_rd [NI];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .ready(ready_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // Builds the expected response from the model and updates the model.
    task automatic push_exp(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int due);
        exp_t e;
        e.inst = k;
        e.due  = due;
        e.err  = addr_bad(a);
        if (e.err) begin
            e.rdata = 32'd0;
        end else if (w) begin
            e.rdata = last_rd[k];
            mdl[k][a[7:2]] = d;
        end else begin
            e.rdata = mdl[k][a[7:2]];
        end
        last_rd[k] = e.rdata;
        sb.push_back(e);
    endtask

    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        req_v[k]   = r;
        we_v[k]    = w;
        addr_v[k]  = a;
        wdata_v[k] = d;
    endtask

    task automatic do_access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        check("accept_busy", 32'(busy_v[k]), 0);
        drive(k, 1'b1, w, a, d);
        push_exp(k, w, a, d, cyc + lat_of(k));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_v[k] && n < 40);
        check("ready_seen", 32'(ready_v[k]), 1);
        req_v[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_ready"}, 32'(ready_v[k]), 0);
            check({tag, "_err"},   32'(err_v[k]),   0);
            check({tag, "_busy"},  32'(busy_v[k]),  0);
            check({tag, "_rdata"}, rdata_v[k],      0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            for (int k = 0; k < NI; k++) begin
                if (ready_v[k]) begin
                    if (sb.size() == 0) begin
                        check("spurious_ready", 32'(ready_v[k]), 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_inst",  k, e.inst);
                        check("resp_cycle", cyc, e.due);
                        check("resp_err",   32'(err_v[k]), 32'(e.err));
                        check("resp_rdata", rdata_v[k], e.rdata);
                    end
                end else begin
                    check("err_without_ready", 32'(err_v[k]), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total  = 0;
        bad    = 0;
        mon_on = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < NI; k++) begin
            drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
            last_rd[k] = 32'd0;
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");
        mon_on = 1'b1;

        // LATENCY=2: basic stores/loads, range edges and rejected addresses.
        do_access(0, 1'b1, 32'h0000_0000, 32'h0000_A5A5);
        do_access(0, 1'b1, 32'h0000_0064, 32'd7);
        do_access(0, 1'b0, 32'h0000_0064, 32'd0);
        do_access(0, 1'b1, 32'h0000_00FC, 32'h0000_005A);
        do_access(0, 1'b0, 32'h0000_00FC, 32'd0);
        do_access(0, 1'b0, 32'h0000_0062, 32'd0);
        do_access(0, 1'b1, 32'h0000_0100, 32'h0000_FFFF);
        do_access(0, 1'b1, 32'h8000_0000, 32'h0BAD_0BAD);
        do_access(0, 1'b1, 32'h0000_0010, 32'h0000_3333);
        do_access(0, 1'b0, 32'h0000_0000, 32'd0);

        // LATENCY=1 with req held high: one access every second cycle.
        @(negedge clk);
        check("l1_accept_busy", 32'(busy_v[1]), 0);
        drive(1, 1'b1, 1'b1, 32'h0, 32'h100);
        push_exp(1, 1'b1, 32'h0, 32'h100, cyc + 1);
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ready_v[1] && n < 6);
            check("l1_ready", 32'(ready_v[1]), 1);
            check("l1_gap", n, (i == 0) ? 1 : 2);
            if (i < 5) begin
                drive(1, 1'b1, 1'b1, ((i + 1) % 2 == 1) ? 32'h4 : 32'h0, 32'h100 + 32'(i + 1));
                push_exp(1, 1'b1, addr_v[1], wdata_v[1], cyc + 2);
            end else begin
                req_v[1] = 1'b0;
            end
        end
        @(negedge clk);
        check("l1_idle_busy", 32'(busy_v[1]), 0);
        do_access(1, 1'b0, 32'h0, 32'd0);
        do_access(1, 1'b0, 32'h4, 32'd0);

        // LATENCY=1: reset coinciding with the RESP cycle of a store suppresses the write.
        do_access(1, 1'b1, 32'h8, 32'h11);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h8, 32'h22);
        begin
            exp_t e;
            e.inst  = 1;
            e.due   = cyc + 1;
            e.err   = 1'b0;
            e.rdata = last_rd[1];
            sb.push_back(e);
        end
        @(negedge clk);
        check("rst_resp_ready", 32'(ready_v[1]), 1);
        reset    = 1'b1;
        req_v[1] = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_resp");
        reset = 1'b0;
        for (int k = 0; k < NI; k++) last_rd[k] = 32'd0;
        do_access(1, 1'b0, 32'h8, 32'd0);

        // LATENCY=2: reset during WAIT discards a pending store.
        @(negedge clk);
        check("rst_wait_accept_busy", 32'(busy_v[0]), 0);
        drive(0, 1'b1, 1'b1, 32'h64, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rst_wait_busy", 32'(busy_v[0]), 1);
        reset    = 1'b1;
        req_v[0] = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_wait");
        reset = 1'b0;
        for (int k = 0; k < NI; k++) last_rd[k] = 32'd0;
        do_access(0, 1'b0, 32'h64, 32'd0);

        // LATENCY=15: busy window, single ready, req/addr wiggling in WAIT ignored.
        do_access(2, 1'b1, 32'h10, 32'h0000_1234);
        @(negedge clk);
        check("l15_accept_busy", 32'(busy_v[2]), 0);
        drive(2, 1'b1, 1'b0, 32'h10, 32'd0);
        push_exp(2, 1'b0, 32'h10, 32'd0, cyc + 15);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("l15_busy", 32'(busy_v[2]), 1);
            if (i < 15) begin
                check("l15_early_ready", 32'(ready_v[2]), 0);
                drive(2, (i % 2 == 1), (i % 2 == 1), (i % 2 == 1) ? 32'h62 : 32'h10, 32'hFFFF_0000);
            end else begin
                check("l15_ready", 32'(ready_v[2]), 1);
                req_v[2] = 1'b0;
            end
        end
        @(negedge clk);
        check("l15_done_busy", 32'(busy_v[2]), 0);
        check("l15_done_ready", 32'(ready_v[2]), 0);
        do_access(2, 1'b0, 32'h10, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
